md_sched: RTL and testbench

Sequencing controller for the multiply/divide resource in the EX stage. It accepts one mult/div/move request per cycle, owns the HI/LO registers, and models fixed MULT/DIV latency with a down-counter. It raises `stall_req` to the hazard unit whenever a request would collide with an operation in flight. Results commit at the end of the latency window, not at issue, so an aborted operation leaves HI/LO intact.

---
 rtl/md_pkg.sv | 18 +
 rtl/md_core.sv | 24 ++
 rtl/md_sched.sv | 90 +++++++++
 tb/tb_md_sched.sv | 189 ++++++++++++++++++
 4 files changed

// File: rtl/md_pkg.sv
// md_pkg: op codes, state encoding, default latencies and op classification for md_sched
package md_pkg;
  localparam logic [3:0] OP_NOP   = 4'd0;
  localparam logic [3:0] OP_MULT  = 4'd1;
  localparam logic [3:0] OP_MULTU = 4'd2;
  localparam logic [3:0] OP_DIV   = 4'd3;
  localparam logic [3:0] OP_DIVU  = 4'd4;
  localparam logic [3:0] OP_MTHI  = 4'd5;
  localparam logic [3:0] OP_MTLO  = 4'd6;
  localparam logic [3:0] OP_MFHI  = 4'd7;
  localparam logic [3:0] OP_MFLO  = 4'd8;
  localparam int MULT_LAT_DEF = 5;
  localparam int DIV_LAT_DEF  = 10;
  typedef enum logic {IDLE = 1'b0, BUSY = 1'b1} state_t;
  function automatic logic is_arith(input logic [3:0] op);
    return (op == OP_MULT) || (op == OP_MULTU) || (op == OP_DIV) || (op == OP_DIVU);
  endfunction
endpackage

// File: rtl/md_core.sv
// md_core: combinational signed/unsigned multiply and divide producing HI/LO (op, rs, rt -> hi, lo)
module md_core import md_pkg::*; (
  input  logic [3:0]  op,
  input  logic [31:0] rs,
  input  logic [31:0] rt,
  output logic [31:0] hi,
  output logic [31:0] lo
);
  logic        sgn;
  logic [63:0] prod;
  logic [31:0] a, b, uq, ur, q, r;
  always_comb begin
    sgn  = (op == OP_DIV);
    prod = (op == OP_MULT) ? {{32{rs[31]}}, rs} * {{32{rt[31]}}, rt} : {32'd0, rs} * {32'd0, rt};
    a    = (sgn && rs[31]) ? -rs : rs;
    b    = (sgn && rt[31]) ? -rt : rt;
    uq   = a / ((b == 32'd0) ? 32'd1 : b);
    ur   = a % ((b == 32'd0) ? 32'd1 : b);
    q    = (sgn && (rs[31] ^ rt[31])) ? -uq : uq;
    r    = (sgn && rs[31]) ? -ur : ur;
    hi   = (op == OP_MULT || op == OP_MULTU) ? prod[63:32] : (rt == 32'd0) ? rs : r;
    lo   = (op == OP_MULT || op == OP_MULTU) ? prod[31:0] : (rt == 32'd0) ? 32'hFFFF_FFFF : q;
  end
endmodule

// File: rtl/md_sched.sv
// md_sched: mult/div sequencer owning HI/LO with fixed latency, stall and accept handshake; optional MD_CANCEL_EN abort
module md_sched import md_pkg::*; #(
  parameter int MULT_LAT = MULT_LAT_DEF,
  parameter int DIV_LAT  = DIV_LAT_DEF,
  parameter int CNT_W    = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  input  logic [3:0]  req_op,
  input  logic [31:0] req_rs,
  input  logic [31:0] req_rt,
  input  logic        cancel,
  output logic        accept,
  output logic        stall_req,
  output logic        busy,
  output logic [31:0] rd_data,
  output logic [31:0] hi,
  output logic [31:0] lo
);
  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [3:0]         op_q, op_d;
  logic [31:0]        rs_q, rs_d, rt_q, rt_d, hi_q, hi_d, lo_q, lo_d, core_hi, core_lo;
  logic               md, kill;
  md_core u_core (.op(op_q), .rs(rs_q), .rt(rt_q), .hi(core_hi), .lo(core_lo));
`ifdef MD_CANCEL_EN
  assign kill = cancel;
`else
  logic unused_cancel;
  assign unused_cancel = cancel;
  assign kill = 1'b0;
`endif
  always_comb begin
    md        = req_valid && (req_op != OP_NOP);
    stall_req = md && (state_q == BUSY);
    accept    = md && (state_q == IDLE) && !kill;
    rd_data   = (accept && req_op == OP_MFHI) ? hi_q : (accept && req_op == OP_MFLO) ? lo_q : 32'd0;
    state_d   = state_q;
    cnt_d     = cnt_q;
    op_d      = op_q;
    rs_d      = rs_q;
    rt_d      = rt_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
    if (state_q == BUSY) begin
      cnt_d = cnt_q - 1'b1;
      if (kill) begin
        state_d = IDLE;
        cnt_d   = '0;
      end else if (cnt_q == CNT_W'(1)) begin
        state_d = IDLE;
        hi_d    = core_hi;
        lo_d    = core_lo;
      end
    end else if (accept) begin
      if (is_arith(req_op)) begin
        state_d = BUSY;
        op_d    = req_op;
        rs_d    = req_rs;
        rt_d    = req_rt;
        cnt_d   = (req_op == OP_MULT || req_op == OP_MULTU) ? CNT_W'(MULT_LAT) : CNT_W'(DIV_LAT);
      end
      hi_d = (req_op == OP_MTHI) ? req_rs : hi_q;
      lo_d = (req_op == OP_MTLO) ? req_rs : lo_q;
    end
  end
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      op_q    <= OP_NOP;
      rs_q    <= '0;
      rt_q    <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      op_q    <= op_d;
      rs_q    <= rs_d;
      rt_q    <= rt_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
    end
  end
  assign busy = (state_q == BUSY);
  assign hi   = hi_q;
  assign lo   = lo_q;
endmodule

// File: tb/tb_md_sched.sv
// tb_md_sched: directed self-checking bench for md_sched
module tb_md_sched;
  import md_pkg::*;
  logic        clk = 1'b0, reset = 1'b0, req_valid = 1'b0, cancel = 1'b0;
  logic [3:0]  req_op = OP_NOP;
  logic [31:0] req_rs = '0, req_rt = '0;
  logic        accept, stall_req, busy;
  logic [31:0] rd_data, hi, lo;
  int          checks = 0, errors = 0;
  md_sched dut (.clk(clk), .reset(reset), .req_valid(req_valid), .req_op(req_op), .req_rs(req_rs),
                .req_rt(req_rt), .cancel(cancel), .accept(accept), .stall_req(stall_req), .busy(busy),
                .rd_data(rd_data), .hi(hi), .lo(lo));
  always #5 clk = ~clk;
  task automatic chk(input string t, input logic ok, input logic [31:0] o, input logic [31:0] e);
    checks++;
    if (ok !== 1'b1) begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", t, o, e);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic req(input logic [3:0] op, input logic [31:0] rs, input logic [31:0] rt);
    req_valid = 1'b1;
    req_op    = op;
    req_rs    = rs;
    req_rt    = rt;
  endtask
  task automatic idle_in();
    req_valid = 1'b0;
    req_op    = OP_NOP;
  endtask
  task automatic wait_idle();
    for (int i = 0; i < 20 && busy; i++) tick();
    chk("wait_idle_timeout", busy === 1'b0, busy, 1'b0);
  endtask
  task automatic arith(input logic [3:0] op, input logic [31:0] rs, input logic [31:0] rt);
    req(op, rs, rt);
    #1;
    chk("arith_accept", accept === 1'b1, accept, 1'b1);
    tick();
    idle_in();
    chk("arith_busy", busy === 1'b1, busy, 1'b1);
    wait_idle();
  endtask
  initial begin
    #12;
    chk("rst_hi", hi === 32'd0, hi, 32'd0);
    chk("rst_lo", lo === 32'd0, lo, 32'd0);
    chk("rst_busy", busy === 1'b0, busy, 1'b0);
    chk("rst_accept", accept === 1'b0, accept, 1'b0);
    chk("rst_stall", stall_req === 1'b0, stall_req, 1'b0);
    chk("rst_rd", rd_data === 32'd0, rd_data, 32'd0);
    reset = 1'b1;
    tick();
    req(OP_MULT, 32'hFFFF_FFFE, 32'd3);
    #1;
    chk("mult_accept", accept === 1'b1, accept, 1'b1);
    chk("mult_nostall", stall_req === 1'b0, stall_req, 1'b0);
    tick();
    idle_in();
    for (int i = 0; i < 5; i++) begin
      chk("mult_busy", busy === 1'b1, busy, 1'b1);
      tick();
    end
    chk("mult_busy_fall", busy === 1'b0, busy, 1'b0);
    chk("mult_hi", hi === 32'hFFFF_FFFF, hi, 32'hFFFF_FFFF);
    chk("mult_lo", lo === 32'hFFFF_FFFA, lo, 32'hFFFF_FFFA);
    req(OP_DIVU, 32'd7, 32'd2);
    #1;
    chk("divu_accept", accept === 1'b1, accept, 1'b1);
    tick();
    req(OP_MFLO, 32'd0, 32'd0);
    chk("divu_lo_held", lo === 32'hFFFF_FFFA, lo, 32'hFFFF_FFFA);
    for (int i = 0; i < 10; i++) begin
      #1;
      chk("divu_stall", stall_req === 1'b1, stall_req, 1'b1);
      chk("divu_noaccept", accept === 1'b0, accept, 1'b0);
      tick();
    end
    #1;
    chk("mflo_stall_low", stall_req === 1'b0, stall_req, 1'b0);
    chk("mflo_accept", accept === 1'b1, accept, 1'b1);
    chk("mflo_rd", rd_data === 32'd3, rd_data, 32'd3);
    chk("divu_hi", hi === 32'd1, hi, 32'd1);
    tick();
    idle_in();
    arith(OP_DIV, 32'hFFFF_FFF9, 32'd2);
    chk("div_neg_lo", lo === 32'hFFFF_FFFD, lo, 32'hFFFF_FFFD);
    chk("div_neg_hi", hi === 32'hFFFF_FFFF, hi, 32'hFFFF_FFFF);
    arith(OP_DIV, 32'd5, 32'd0);
    chk("div0_lo", lo === 32'hFFFF_FFFF, lo, 32'hFFFF_FFFF);
    chk("div0_hi", hi === 32'd5, hi, 32'd5);
    arith(OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF);
    chk("divovf_lo", lo === 32'h8000_0000, lo, 32'h8000_0000);
    chk("divovf_hi", hi === 32'd0, hi, 32'd0);
    arith(OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    chk("multu_hi", hi === 32'hFFFF_FFFE, hi, 32'hFFFF_FFFE);
    chk("multu_lo", lo === 32'd1, lo, 32'd1);
    req(OP_MTHI, 32'h1234, 32'd0);
    #1;
    chk("mthi_accept", accept === 1'b1, accept, 1'b1);
    tick();
    req(OP_MFHI, 32'd0, 32'd0);
    #1;
    chk("mfhi_nostall", stall_req === 1'b0, stall_req, 1'b0);
    chk("mfhi_accept", accept === 1'b1, accept, 1'b1);
    chk("mfhi_rd", rd_data === 32'h1234, rd_data, 32'h1234);
    tick();
    req(OP_MTLO, 32'hABCD, 32'd0);
    tick();
    req(OP_MFLO, 32'd0, 32'd0);
    #1;
    chk("mtlo_rd", rd_data === 32'hABCD, rd_data, 32'hABCD);
    chk("mtlo_hi_kept", hi === 32'h1234, hi, 32'h1234);
    tick();
    req(OP_NOP, 32'hDEAD, 32'd0);
    #1;
    chk("nop_accept", accept === 1'b0, accept, 1'b0);
    chk("nop_rd", rd_data === 32'd0, rd_data, 32'd0);
    tick();
    chk("nop_busy", busy === 1'b0, busy, 1'b0);
    req(OP_MULT, 32'd3, 32'd4);
    tick();
    req(OP_MULT, 32'd2, 32'd5);
    for (int i = 0; i < 5; i++) begin
      #1;
      chk("b2b_stall", stall_req === 1'b1, stall_req, 1'b1);
      tick();
    end
    #1;
    chk("b2b_accept", accept === 1'b1, accept, 1'b1);
    chk("b2b_first_lo", lo === 32'd12, lo, 32'd12);
    tick();
    idle_in();
    wait_idle();
    chk("b2b_second_lo", lo === 32'd10, lo, 32'd10);
    chk("b2b_second_hi", hi === 32'd0, hi, 32'd0);
`ifdef MD_CANCEL_EN
    req(OP_MULT, 32'd7, 32'd7);
    tick();
    idle_in();
    for (int i = 0; i < 4; i++) tick();
    chk("cancel_busy5", busy === 1'b1, busy, 1'b1);
    cancel = 1'b1;
    tick();
    cancel = 1'b0;
    chk("cancel_busy", busy === 1'b0, busy, 1'b0);
    chk("cancel_lo", lo === 32'd10, lo, 32'd10);
    chk("cancel_hi", hi === 32'd0, hi, 32'd0);
    req(OP_MFLO, 32'd0, 32'd0);
    cancel = 1'b1;
    #1;
    chk("cancel_idle_accept", accept === 1'b0, accept, 1'b0);
    chk("cancel_idle_stall", stall_req === 1'b0, stall_req, 1'b0);
    chk("cancel_idle_rd", rd_data === 32'd0, rd_data, 32'd0);
    cancel = 1'b0;
    idle_in();
    tick();
`endif
    req(OP_DIV, 32'd9, 32'd2);
    tick();
    idle_in();
    tick();
    tick();
    chk("middiv_busy", busy === 1'b1, busy, 1'b1);
    #2;
    reset = 1'b0;
    #1;
    chk("arst_busy", busy === 1'b0, busy, 1'b0);
    chk("arst_lo", lo === 32'd0, lo, 32'd0);
    chk("arst_hi", hi === 32'd0, hi, 32'd0);
    chk("arst_rd", rd_data === 32'd0, rd_data, 32'd0);
    tick();
    reset = 1'b1;
    for (int i = 0; i < 12; i++) tick();
    chk("post_rst_busy", busy === 1'b0, busy, 1'b0);
    chk("post_rst_lo", lo === 32'd0, lo, 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
  initial begin
    #50000;
    $display("FAIL global_timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end
endmodule
